// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI controller between requesters A and B.
// The owner's strobes and data pass straight through to the controller;
// the non-owner sees a permanently full/empty, never-ready buffer.
// Between owners the arbiter drains stale response bytes. An owner that
// stays idle for TIMEOUT cycles while the controller is empty is
// force-released, and a sticky error flag records it.
module spi_arbiter #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  // requester A
  input  logic       a_req,
  output logic       a_gnt,
  input  logic       a_rd,
  input  logic       a_wr,
  input  logic [7:0] a_din,
  input  logic       a_ignore_response,
  output logic [7:0] a_dout,
  output logic       a_data_avail,
  output logic       a_buffer_empty,
  output logic       a_buffer_full,
  // requester B
  input  logic       b_req,
  output logic       b_gnt,
  input  logic       b_rd,
  input  logic       b_wr,
  input  logic [7:0] b_din,
  input  logic       b_ignore_response,
  output logic [7:0] b_dout,
  output logic       b_data_avail,
  output logic       b_buffer_empty,
  output logic       b_buffer_full,
  // SPI controller side
  output logic       spi_rd,
  output logic       spi_wr,
  output logic [7:0] spi_din,
  output logic       spi_ignore_response,
  input  logic [7:0] spi_dout,
  input  logic       spi_data_avail,
  input  logic       spi_buffer_empty,
  input  logic       spi_buffer_full,
  // error reporting
  output logic       timeout_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_a_gnt;
  logic        r_b_gnt;
  logic        r_last_b;       // last owner: 1 = B, 0 = A
  logic [15:0] r_cnt;
  logic        r_timeout_err;

  logic w_own_a;
  logic w_own_b;
  logic w_drain;
  logic w_own_strobe;
  logic w_owner_req;
  logic w_expire;

  assign w_own_a      = (r_state == GRANT_A);
  assign w_own_b      = (r_state == GRANT_B);
  assign w_drain      = (r_state == DRAIN);
  assign w_own_strobe = (w_own_a & (a_rd | a_wr)) | (w_own_b & (b_rd | b_wr));
  assign w_owner_req  = w_own_a ? a_req : b_req;
  // A strobe in the would-be expiry cycle restarts the count instead.
  assign w_expire     = (w_own_a | w_own_b) & ~w_own_strobe & spi_buffer_empty &
                        (r_cnt == LP_CNT_LAST);

  // Arbitration FSM, idle-timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_a_gnt       <= 1'b0;
      r_b_gnt       <= 1'b0;
      r_last_b      <= 1'b1;
      r_cnt         <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      // A set event beats a simultaneous clear.
      r_timeout_err <= w_expire | (r_timeout_err & ~err_clr);
      case (r_state)
        IDLE: begin
          r_cnt <= 16'd0;
          if (a_req && (!b_req || FIXED_PRIO || r_last_b)) begin
            r_state <= GRANT_A;
            r_a_gnt <= 1'b1;
          end else if (b_req) begin
            r_state <= GRANT_B;
            r_b_gnt <= 1'b1;
          end
        end
        GRANT_A, GRANT_B: begin
          if (!w_owner_req || w_expire) begin
            r_state  <= DRAIN;
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_last_b <= w_own_b;
            r_cnt    <= 16'd0;
          end else if (w_own_strobe) begin
            r_cnt <= 16'd0;
          end else if (spi_buffer_empty) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (spi_buffer_empty && !spi_data_avail) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_a_gnt <= 1'b0;
          r_b_gnt <= 1'b0;
        end
      endcase
    end
  end

  assign a_gnt       = r_a_gnt;
  assign b_gnt       = r_b_gnt;
  assign timeout_err = r_timeout_err;

  // Controller side: only the owner reaches it; DRAIN pops leftover bytes.
  assign spi_rd              = (w_own_a & a_rd) | (w_own_b & b_rd) | (w_drain & spi_data_avail);
  assign spi_wr              = (w_own_a & a_wr) | (w_own_b & b_wr);
  assign spi_din             = w_own_a ? a_din : (w_own_b ? b_din : 8'h00);
  assign spi_ignore_response = (w_own_a & a_ignore_response) | (w_own_b & b_ignore_response);

  // Requester side: the non-owner sees a buffer that can neither accept nor deliver.
  assign a_dout         = w_own_a ? spi_dout : 8'h00;
  assign a_data_avail   = w_own_a & spi_data_avail;
  assign a_buffer_empty = w_own_a ? spi_buffer_empty : 1'b1;
  assign a_buffer_full  = w_own_a ? spi_buffer_full : 1'b1;
  assign b_dout         = w_own_b ? spi_dout : 8'h00;
  assign b_data_avail   = w_own_b & spi_data_avail;
  assign b_buffer_empty = w_own_b ? spi_buffer_empty : 1'b1;
  assign b_buffer_full  = w_own_b ? spi_buffer_full : 1'b1;

endmodule
